// File: rtl/s_mem_fill_engine.sv
// Fill engine for the RC4 S-array RAM: writes DEPTH words (identity, descending or constant).
// Define S_FILL_VERIFY_EN to add a readback pass that raises a sticky verify_err on mismatch.
module s_mem_fill_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  output logic              verify_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_VERIFY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] END_IDX  = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_next;
  logic [ADDR_W:0]   idx_prev;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fill_q;

  assign idx_next = idx + 1'b1;
  assign idx_prev = idx - 1'b1;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [DATA_W-1:0] fv,
                                                input logic [ADDR_W:0] i);
    logic [ADDR_W:0] down;
    down = LAST_IDX - i;
    case (m)
      2'd1:    pattern = DATA_W'(down);
      2'd2:    pattern = fv;
      default: pattern = DATA_W'(i);
    endcase
  endfunction

  // In WRITE, idx is the next address to write; in VERIFY it counts pass cycles 0..DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      mode_q      <= '0;
      fill_q      <= '0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q      <= mode;
            fill_q      <= fill_value;
            idx         <= (ADDR_W+1)'(1);
            mem_wren    <= 1'b1;
            mem_address <= '0;
            mem_data    <= pattern(mode, fill_value, '0);
            busy        <= 1'b1;
            state       <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (idx == END_IDX) begin
            mem_wren <= 1'b0;
`ifdef S_FILL_VERIFY_EN
            idx         <= '0;
            mem_address <= '0;
            state       <= ST_VERIFY;
`else
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
`endif
          end else begin
            mem_address <= idx[ADDR_W-1:0];
            mem_data    <= pattern(mode_q, fill_q, idx);
            idx         <= idx_next;
          end
        end
`ifdef S_FILL_VERIFY_EN
        ST_VERIFY: begin
          if (idx == END_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            idx <= idx_next;
            if (idx_next < END_IDX) mem_address <= idx_next[ADDR_W-1:0];
          end
        end
`endif
        ST_DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef S_FILL_VERIFY_EN
  // mem_q carries the word addressed one cycle earlier, hence idx_prev.
  always_ff @(posedge clk) begin
    if (reset) begin
      verify_err <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      verify_err <= 1'b0;
    end else if (state == ST_VERIFY && idx != '0 &&
                 mem_q != pattern(mode_q, fill_q, idx_prev)) begin
      verify_err <= 1'b1;
    end
  end
`else
  logic unused_q;
  assign unused_q   = ^mem_q;
  assign verify_err = 1'b0;
`endif

endmodule
